// File: rtl/pid_pwm_if.sv
// pid_pwm_if: control-word handshake and gate-drive outputs of the PID PWM stage
interface pid_pwm_if;
    logic       ena;
    logic [7:0] u_in;
    logic       u_valid;
    logic       u_ready;
    logic       pwm_h;
    logic       pwm_l;
    logic       period_start;
    logic [7:0] duty_q;
    modport master (
        output ena, u_in, u_valid,
        input  u_ready, pwm_h, pwm_l, period_start, duty_q
    );
    modport slave (
        input  ena, u_in, u_valid,
        output u_ready, pwm_h, pwm_l, period_start, duty_q
    );
endinterface

// File: rtl/pid_pwm_stage.sv
// pid_pwm_stage: signed control word to dead-time protected complementary PWM; define PID_PWM_SLEW_EN to slew-limit the duty per period
module pid_pwm_stage #(
    parameter int DEADTIME  = 2,
    parameter int SLEW_STEP = 8
) (
    input logic      clk,
    input logic      rst,
    pid_pwm_if.slave p
);
    localparam logic [3:0] DT = 4'(DEADTIME);
    if (DEADTIME < 0 || DEADTIME > 15) begin : g_dt_chk
        $error("DEADTIME out of range 0..15");
    end
    if (SLEW_STEP < 1 || SLEW_STEP > 255) begin : g_step_chk
        $error("SLEW_STEP out of range 1..255");
    end
    logic [7:0] cnt_q, cnt_d, duty_q, duty_d, shadow_q, shadow_d;
    logic       full_q, full_d, raw_q, raw_d;
    logic [3:0] dt_q, dt_d;
    logic       wrap, xfer, settled;
    assign wrap    = p.ena && cnt_q == 8'd254;
    assign xfer    = p.u_valid && p.u_ready;
    assign settled = dt_q == DT;
    // period counter, shadow handshake, raw comparator and dead-time timer
    always_comb begin
        cnt_d    = !p.ena ? 8'd0 : wrap ? 8'd0 : cnt_q + 8'd1;
        shadow_d = xfer ? p.u_in ^ 8'h80 : shadow_q;
        full_d   = xfer ? 1'b1 : wrap ? 1'b0 : full_q;
        raw_d    = p.ena && cnt_q < duty_q;
        dt_d     = (!p.ena || raw_d != raw_q) ? 4'd0 : settled ? dt_q : dt_q + 4'd1;
    end
`ifdef PID_PWM_SLEW_EN
    localparam logic [7:0] STEP = 8'(SLEW_STEP);
    logic [7:0] target_q, target_d, up, dn;
    // at each wrap the duty steps toward the target; the step never exceeds the gap so no overshoot
    always_comb begin
        target_d = wrap && full_q ? shadow_q : target_q;
        up       = target_d - duty_q;
        dn       = duty_q - target_d;
        duty_d   = !wrap ? duty_q
                 : target_d >= duty_q ? duty_q + (up < STEP ? up : STEP)
                 : duty_q - (dn < STEP ? dn : STEP);
    end
    // slew target, reset to the zero-control midpoint
    always_ff @(posedge clk or posedge rst) begin
        if (rst) target_q <= 8'h80;
        else     target_q <= target_d;
    end
`else
    // the shadow lands directly in the active duty at the wrap
    always_comb begin
        duty_d = wrap && full_q ? shadow_q : duty_q;
    end
`endif
    // state registers; reset aborts the period and drops any pending shadow value
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q    <= 8'd0;
            duty_q   <= 8'h80;
            shadow_q <= 8'd0;
            full_q   <= 1'b0;
            raw_q    <= 1'b0;
            dt_q     <= 4'd0;
        end else begin
            cnt_q    <= cnt_d;
            duty_q   <= duty_d;
            shadow_q <= shadow_d;
            full_q   <= full_d;
            raw_q    <= raw_d;
            dt_q     <= dt_d;
        end
    end
    assign p.u_ready      = !rst && p.ena && !full_q;
    assign p.period_start = !rst && p.ena && cnt_q == 8'd0;
    assign p.pwm_h        = !rst && p.ena && raw_q && settled;
    assign p.pwm_l        = !rst && p.ena && !raw_q && settled;
    assign p.duty_q       = duty_q;
endmodule

// File: tb/tb_pid_pwm_stage.sv
// tb_pid_pwm_stage: randomized and directed checks of pid_pwm_stage against a period-level reference model
module tb_pid_pwm_stage;
    localparam int DT   = 2;
    localparam int STEP = 8;
    logic clk = 1'b0;
    logic rst = 1'b1;
    pid_pwm_if bus ();
    pid_pwm_stage #(.DEADTIME(DT), .SLEW_STEP(STEP)) dut (.clk(clk), .rst(rst), .p(bus));
    always #5 clk = ~clk;
    int n_checks = 0;
    int n_fail   = 0;
    int m_cnt;
    int m_duty;
`ifdef PID_PWM_SLEW_EN
    int m_target;
`endif
    bit [7:0] m_shadow[$];
    bit       hist[$];
    // a gate is on once raw has held its level for the current and DT previous cycles
    function automatic bit run_of(bit v);
        if (hist.size() < DT + 1) return 1'b0;
        for (int i = 0; i <= DT; i++)
            if (hist[hist.size() - 1 - i] != v) return 1'b0;
        return 1'b1;
    endfunction
    function automatic logic e_h();     return !rst && bus.ena && run_of(1'b1); endfunction
    function automatic logic e_l();     return !rst && bus.ena && run_of(1'b0); endfunction
    function automatic logic e_ready(); return !rst && bus.ena && m_shadow.size() == 0; endfunction
    function automatic logic e_ps();    return !rst && bus.ena && m_cnt == 0; endfunction
    task automatic m_reset();
        m_cnt  = 0;
        m_duty = 128;
`ifdef PID_PWM_SLEW_EN
        m_target = 128;
`endif
        m_shadow.delete();
        hist.delete();
        hist.push_back(1'b0);
    endtask
    // advance one clock; the model consumes the inputs that were stable at the edge
    task automatic tick();
        bit en, wrap, xfer, raw_n;
        @(posedge clk);
        if (rst) m_reset();
        else begin
            en    = bus.ena;
            wrap  = en && m_cnt == 254;
            xfer  = en && bus.u_valid && m_shadow.size() == 0;
            raw_n = en && m_cnt < m_duty;
`ifdef PID_PWM_SLEW_EN
            if (wrap && m_shadow.size() != 0) m_target = m_shadow.pop_front();
            if (wrap) begin
                if (m_target > m_duty) m_duty += (m_target - m_duty < STEP) ? m_target - m_duty : STEP;
                else                   m_duty -= (m_duty - m_target < STEP) ? m_duty - m_target : STEP;
            end
`else
            if (wrap && m_shadow.size() != 0) m_duty = m_shadow.pop_front();
`endif
            if (xfer) m_shadow.push_back(bus.u_in ^ 8'h80);
            m_cnt = (!en || wrap) ? 0 : m_cnt + 1;
            if (!en) begin
                hist.delete();
                hist.push_back(1'b0);
            end else begin
                hist.push_back(raw_n);
                if (hist.size() > 20) void'(hist.pop_front());
            end
        end
        #1;
    endtask
    task automatic test_reset();
        bus.ena = 1'b1; bus.u_valid = 1'b0; bus.u_in = 8'h00;
        rst = 1'b1;
        m_reset();
        repeat (3) tick();
        n_checks += 5;
        if (bus.duty_q !== 8'd128) begin n_fail++; $display("FAIL reset_duty got %0d exp 128", bus.duty_q); end
        if (bus.pwm_h !== 1'b0) begin n_fail++; $display("FAIL reset_pwm_h got %b exp 0", bus.pwm_h); end
        if (bus.pwm_l !== 1'b0) begin n_fail++; $display("FAIL reset_pwm_l got %b exp 0", bus.pwm_l); end
        if (bus.period_start !== 1'b0) begin n_fail++; $display("FAIL reset_period_start got %b exp 0", bus.period_start); end
        if (bus.u_ready !== 1'b0) begin n_fail++; $display("FAIL reset_u_ready got %b exp 0", bus.u_ready); end
        rst = 1'b0;
    endtask
    task automatic test_idle();
        int h = 0, ps = 0, k = 0;
        repeat (300) tick();
        while (m_cnt != 0 && k < 300) begin tick(); k++; end
        n_checks++;
        if (bus.period_start !== 1'b1) begin n_fail++; $display("FAIL idle_align period_start got %b exp 1", bus.period_start); end
        for (int i = 0; i < 255; i++) begin
            h += int'(bus.pwm_h);
            ps += int'(bus.period_start);
            tick();
        end
        n_checks += 4;
        if (bus.period_start !== 1'b1) begin n_fail++; $display("FAIL idle_period_len period_start got %b exp 1", bus.period_start); end
        if (ps != 1) begin n_fail++; $display("FAIL idle_ps_count got %0d exp 1", ps); end
        if (h != 128 - DT) begin n_fail++; $display("FAIL idle_pwm_h_cycles got %0d exp %0d", h, 128 - DT); end
        if (bus.duty_q !== 8'd128) begin n_fail++; $display("FAIL idle_duty got %0d exp 128", bus.duty_q); end
    endtask
    task automatic test_full_scale();
        int k = 0, h = 0, l = 0;
        bit leak = 0;
        while (m_cnt != 10 && k < 300) begin tick(); k++; end
        bus.u_in = 8'h7F; bus.u_valid = 1'b1;
        n_checks++;
        if (bus.u_ready !== 1'b1) begin n_fail++; $display("FAIL full_ready_at_10 got %b exp 1", bus.u_ready); end
        tick();
        bus.u_valid = 1'b0;
        k = 0;
        while (m_cnt != 0 && k < 300) begin
            if (bus.u_ready !== 1'b0) leak = 1;
            tick(); k++;
        end
        n_checks += 4;
        if (k >= 300) begin n_fail++; $display("FAIL full_wrap_timeout waited %0d exp <300", k); end
        if (leak) begin n_fail++; $display("FAIL full_ready_held got 1 exp 0 before wrap"); end
        if (bus.u_ready !== 1'b1) begin n_fail++; $display("FAIL full_ready_after_wrap got %b exp 1", bus.u_ready); end
`ifdef PID_PWM_SLEW_EN
        if (bus.duty_q !== 8'd136) begin n_fail++; $display("FAIL full_duty_slew got %0d exp 136", bus.duty_q); end
        for (int i = 0; i < 15; i++) begin
            k = 0;
            tick();
            while (m_cnt != 0 && k < 300) begin tick(); k++; end
        end
        n_checks++;
        if (bus.duty_q !== 8'd255) begin n_fail++; $display("FAIL full_duty_slew_end got %0d exp 255", bus.duty_q); end
`else
        if (bus.duty_q !== 8'd255) begin n_fail++; $display("FAIL full_duty got %0d exp 255", bus.duty_q); end
`endif
        repeat (20) tick();
        for (int i = 0; i < 255; i++) begin
            h += int'(bus.pwm_h); l += int'(bus.pwm_l);
            tick();
        end
        n_checks += 2;
        if (h != 255) begin n_fail++; $display("FAIL full_pwm_h_steady got %0d exp 255", h); end
        if (l != 0) begin n_fail++; $display("FAIL full_pwm_l_off got %0d exp 0", l); end
    endtask
    task automatic test_min();
        int k = 0, h = 0, l = 0;
        while (bus.u_ready !== 1'b1 && k < 600) begin tick(); k++; end
        bus.u_in = 8'h80; bus.u_valid = 1'b1;
        tick();
        bus.u_valid = 1'b0;
        k = 0;
        while (m_duty != 0 && k < 255 * 40) begin tick(); k++; end
        n_checks++;
        if (bus.duty_q !== 8'd0) begin n_fail++; $display("FAIL min_duty got %0d exp 0", bus.duty_q); end
        repeat (20) tick();
        for (int i = 0; i < 255; i++) begin
            h += int'(bus.pwm_h); l += int'(bus.pwm_l);
            tick();
        end
        n_checks += 2;
        if (l != 255) begin n_fail++; $display("FAIL min_pwm_l_steady got %0d exp 255", l); end
        if (h != 0) begin n_fail++; $display("FAIL min_pwm_h_off got %0d exp 0", h); end
    endtask
    task automatic test_dead();
        int k = 0, run = 0, gaps = 0;
        while (bus.u_ready !== 1'b1 && k < 600) begin tick(); k++; end
        bus.u_in = 8'hE4; bus.u_valid = 1'b1;
        tick();
        bus.u_valid = 1'b0;
        k = 0;
        while (m_duty != 100 && k < 255 * 40) begin tick(); k++; end
        n_checks++;
        if (bus.duty_q !== 8'd100) begin n_fail++; $display("FAIL dead_duty got %0d exp 100", bus.duty_q); end
        repeat (20) tick();
        for (int i = 0; i < 510; i++) begin
            n_checks++;
            if (bus.pwm_h === 1'b1 && bus.pwm_l === 1'b1) begin n_fail++; $display("FAIL dead_overlap got 11 exp never both"); end
            if (bus.pwm_h === 1'b0 && bus.pwm_l === 1'b0) run++;
            else if (run > 0) begin
                n_checks++; gaps++;
                if (run != DT) begin n_fail++; $display("FAIL dead_gap_len got %0d exp %0d", run, DT); end
                run = 0;
            end
            tick();
        end
        n_checks++;
        if (gaps < 3) begin n_fail++; $display("FAIL dead_gap_count got %0d exp >=3", gaps); end
    endtask
    task automatic test_reset_mid();
        int k = 0;
        bit bad = 0;
        while (bus.u_ready !== 1'b1 && k < 600) begin tick(); k++; end
        while (m_cnt > 90 && k < 900) begin tick(); k++; end
        bus.u_in = 8'h40; bus.u_valid = 1'b1;
        tick();
        bus.u_valid = 1'b0;
        k = 0;
        while (m_cnt != 100 && k < 300) begin tick(); k++; end
        n_checks++;
        if (bus.u_ready !== 1'b0) begin n_fail++; $display("FAIL rmid_shadow_full ready got %b exp 0", bus.u_ready); end
        rst = 1'b1;
        #1;
        m_reset();
        n_checks += 5;
        if (bus.duty_q !== 8'd128) begin n_fail++; $display("FAIL rmid_duty got %0d exp 128", bus.duty_q); end
        if (bus.pwm_h !== 1'b0) begin n_fail++; $display("FAIL rmid_pwm_h got %b exp 0", bus.pwm_h); end
        if (bus.pwm_l !== 1'b0) begin n_fail++; $display("FAIL rmid_pwm_l got %b exp 0", bus.pwm_l); end
        if (bus.period_start !== 1'b0) begin n_fail++; $display("FAIL rmid_period_start got %b exp 0", bus.period_start); end
        if (bus.u_ready !== 1'b0) begin n_fail++; $display("FAIL rmid_u_ready got %b exp 0", bus.u_ready); end
        repeat (2) tick();
        rst = 1'b0;
        for (int i = 0; i < 600; i++) begin
            if (bus.duty_q !== 8'd128) bad = 1;
            tick();
        end
        n_checks += 2;
        if (bad) begin n_fail++; $display("FAIL rmid_shadow_discarded duty_q got %0d exp 128", bus.duty_q); end
        if (bus.u_ready !== 1'b1) begin n_fail++; $display("FAIL rmid_ready_after got %b exp 1", bus.u_ready); end
    endtask
    task automatic test_random();
        for (int i = 0; i < 6000; i++) begin
            bus.u_valid = ($urandom % 4) == 0;
            bus.u_in    = 8'($urandom);
            if ($urandom % 700 == 0) bus.ena = !bus.ena;
            tick();
            n_checks += 6;
            if (bus.duty_q !== 8'(m_duty)) begin n_fail++; $display("FAIL rnd_duty cyc %0d got %0d exp %0d", i, bus.duty_q, m_duty); end
            if (bus.u_ready !== e_ready()) begin n_fail++; $display("FAIL rnd_u_ready cyc %0d got %b exp %b", i, bus.u_ready, e_ready()); end
            if (bus.period_start !== e_ps()) begin n_fail++; $display("FAIL rnd_period_start cyc %0d got %b exp %b", i, bus.period_start, e_ps()); end
            if (bus.pwm_h !== e_h()) begin n_fail++; $display("FAIL rnd_pwm_h cyc %0d got %b exp %b", i, bus.pwm_h, e_h()); end
            if (bus.pwm_l !== e_l()) begin n_fail++; $display("FAIL rnd_pwm_l cyc %0d got %b exp %b", i, bus.pwm_l, e_l()); end
            if (bus.pwm_h === 1'b1 && bus.pwm_l === 1'b1) begin n_fail++; $display("FAIL rnd_overlap cyc %0d got 11 exp never both", i); end
        end
        bus.ena = 1'b1;
    endtask
    initial begin
        test_reset();
        test_idle();
        test_full_scale();
        test_min();
        test_dead();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
